// File: rtl/motor_pwm_driver.sv
// Two-wheel H-bridge driver: command-to-duty mapping, slew-limited ramp,
// period-aligned PWM with direction bits, and a command-stream watchdog.
module motor_pwm_driver #(
  parameter int PWM_PERIOD      = 1000,
  parameter int FULL_DUTY       = 1000,
  parameter int SLOW_DUTY       = 400,
  parameter int RAMP_STEP       = 10,
  parameter int RAMP_DIV        = 5000,
  parameter int WATCHDOG_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] drive_command,
  input  logic       valid,
  output logic       left_pwm,
  output logic       right_pwm,
  output logic       left_dir,
  output logic       right_dir,
  output logic       moving,
  output logic       watchdog_fault
);

  localparam int DW = $clog2(PWM_PERIOD) + 2;
  localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int TW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);

  localparam logic [DW-1:0] POS_FULL = DW'(FULL_DUTY);
  localparam logic [DW-1:0] NEG_FULL = DW'(-FULL_DUTY);
  localparam logic [DW-1:0] POS_SLOW = DW'(SLOW_DUTY);
  localparam logic signed [DW-1:0] STEP      = DW'(RAMP_STEP);
  localparam logic signed [DW:0]   STEP_WIDE = (DW + 1)'(RAMP_STEP);
  localparam logic signed [DW:0]   STEP_NEG  = (DW + 1)'(-RAMP_STEP);

  logic [CW-1:0] pwm_cnt_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [WW-1:0] wd_cnt_reg;
  logic          fault_reg;
  logic          tick;
  logic          period_end;
  logic          wd_expire;

  // Index 0 is the left wheel, index 1 the right wheel.
  logic [1:0][DW-1:0] cmd_target;
  logic [1:0][DW-1:0] ramp_duty;
  logic [1:0]         pwm_bit;
  logic [1:0]         dir_bit;

  assign tick       = (tick_cnt_reg == TW'(RAMP_DIV - 1));
  assign period_end = (pwm_cnt_reg == CW'(PWM_PERIOD - 1));
  // Expiry is the edge where the idle count would reach the limit; a valid
  // strobe on that same edge suppresses it.
  assign wd_expire  = !valid && (wd_cnt_reg == WW'(WATCHDOG_CYCLES - 1));

  always_comb begin
    cmd_target = '0;
    case (drive_command)
      3'd1: begin cmd_target[0] = NEG_FULL; cmd_target[1] = POS_FULL; end
      3'd2: begin cmd_target[0] = POS_SLOW; cmd_target[1] = POS_FULL; end
      3'd3: begin cmd_target[0] = POS_FULL; cmd_target[1] = POS_FULL; end
      3'd4: begin cmd_target[0] = POS_FULL; cmd_target[1] = POS_SLOW; end
      3'd5: begin cmd_target[0] = POS_FULL; cmd_target[1] = NEG_FULL; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_reg  <= '0;
      tick_cnt_reg <= '0;
      wd_cnt_reg   <= '0;
      fault_reg    <= 1'b0;
    end else begin
      tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
      pwm_cnt_reg  <= period_end ? '0 : pwm_cnt_reg + 1'b1;
      if (valid) begin
        wd_cnt_reg <= '0;
        fault_reg  <= 1'b0;
      end else if (wd_cnt_reg != WW'(WATCHDOG_CYCLES)) begin
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
        if (wd_expire) fault_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_wheel
    logic signed [DW-1:0] target_reg;
    logic signed [DW-1:0] ramp_reg;
    logic signed [DW-1:0] applied_reg;
    logic signed [DW-1:0] ramp_next;
    logic signed [DW:0]   diff;
    logic        [DW-1:0] applied_mag;
    logic                 pwm_reg;
    logic                 dir_reg;

    // Step toward the target, clamping the final step so it never overshoots.
    always_comb begin
      diff = {target_reg[DW-1], target_reg} - {ramp_reg[DW-1], ramp_reg};
      if (diff > STEP_WIDE)     ramp_next = ramp_reg + STEP;
      else if (diff < STEP_NEG) ramp_next = ramp_reg - STEP;
      else                      ramp_next = target_reg;
      applied_mag = $unsigned(applied_reg[DW-1] ? -applied_reg : applied_reg);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        target_reg  <= '0;
        ramp_reg    <= '0;
        applied_reg <= '0;
        pwm_reg     <= 1'b0;
        dir_reg     <= 1'b1;
      end else begin
        if (valid)          target_reg <= $signed(cmd_target[gi]);
        else if (wd_expire) target_reg <= '0;
        if (tick) ramp_reg <= ramp_next;
        // Duty and direction only change on the period boundary.
        if (period_end) begin
          applied_reg <= ramp_reg;
          dir_reg     <= !ramp_reg[DW-1];
        end
        pwm_reg <= ({{(DW - CW){1'b0}}, pwm_cnt_reg} < applied_mag);
      end
    end

    assign ramp_duty[gi] = ramp_reg;
    assign pwm_bit[gi]   = pwm_reg;
    assign dir_bit[gi]   = dir_reg;
  end

  assign left_pwm       = pwm_bit[0];
  assign right_pwm      = pwm_bit[1];
  assign left_dir       = dir_bit[0];
  assign right_dir      = dir_bit[1];
  assign moving         = (ramp_duty[0] != '0) || (ramp_duty[1] != '0);
  assign watchdog_fault = fault_reg;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with a short period, fast ramp and
// a 100-cycle watchdog so every scenario completes in a few hundred cycles.
module tb_motor_pwm_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] drive_command;
  logic       valid;
  logic       left_pwm, right_pwm, left_dir, right_dir, moving, watchdog_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_pwm_driver #(
    .PWM_PERIOD(10), .FULL_DUTY(10), .SLOW_DUTY(4),
    .RAMP_STEP(2), .RAMP_DIV(4), .WATCHDOG_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .drive_command(drive_command), .valid(valid),
    .left_pwm(left_pwm), .right_pwm(right_pwm), .left_dir(left_dir),
    .right_dir(right_dir), .moving(moving), .watchdog_fault(watchdog_fault)
  );

  logic signed [5:0] ramp_l, ramp_r;
  assign ramp_l = dut.ramp_duty[0];
  assign ramp_r = dut.ramp_duty[1];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_high(input int n, output int lc, output int rc);
    lc = 0;
    rc = 0;
    repeat (n) begin
      step();
      lc += int'(left_pwm);
      rc += int'(right_pwm);
    end
  endtask

  task automatic test_reset();
    int lc, rc;
    reset = 1'b1; valid = 1'b0; drive_command = 3'd0;
    repeat (3) step();
    checks++;
    if ({left_pwm, right_pwm, moving, watchdog_fault} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs: got %b expected 0000", {left_pwm, right_pwm, moving, watchdog_fault});
    end
    checks++;
    if ({left_dir, right_dir} !== 2'b11) begin
      errors++; $display("FAIL reset_dirs: got %b expected 11", {left_dir, right_dir});
    end
    reset = 1'b0;
    count_high(20, lc, rc);
    checks++;
    if (lc + rc != 0 || moving !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: high=%0d moving=%b expected 0/0", lc + rc, moving);
    end
    $display("test_reset done");
  endtask

  task automatic test_straight();
    logic signed [5:0] prev;
    int nchg, last_t, lc, rc;
    valid = 1'b1; drive_command = 3'd3;
    step();
    valid = 1'b0;
    checks++;
    if (ramp_l !== 6'sd0) begin errors++; $display("FAIL straight_start: ramp_l=%0d expected 0", ramp_l); end
    prev = ramp_l; nchg = 0; last_t = 0;
    for (int t = 1; t <= 40; t++) begin
      step();
      checks++;
      if (ramp_r !== ramp_l) begin errors++; $display("FAIL straight_lr: ramp_r=%0d expected %0d", ramp_r, ramp_l); end
      if (ramp_l !== prev) begin
        checks++;
        if (int'(ramp_l) - int'(prev) != 2) begin
          errors++; $display("FAIL straight_step: delta=%0d expected 2", int'(ramp_l) - int'(prev));
        end
        if (nchg > 0) begin
          checks++;
          if (t - last_t != 4) begin errors++; $display("FAIL straight_interval: got %0d expected 4", t - last_t); end
        end
        nchg++; last_t = t; prev = ramp_l;
      end
    end
    checks++;
    if (nchg != 5 || ramp_l !== 6'sd10) begin
      errors++; $display("FAIL straight_final: steps=%0d ramp=%0d expected 5/10", nchg, ramp_l);
    end
    count_high(10, lc, rc);
    checks++;
    if (lc != 10 || rc != 10) begin errors++; $display("FAIL straight_pwm: got %0d/%0d expected 10/10", lc, rc); end
    checks++;
    if ({moving, left_dir, right_dir} !== 3'b111) begin
      errors++; $display("FAIL straight_flags: got %b expected 111", {moving, left_dir, right_dir});
    end
    $display("test_straight done");
  endtask

  task automatic test_fast_left();
    logic signed [5:0] prev;
    logic prev_dir;
    int flips, lc, rc;
    valid = 1'b1; drive_command = 3'd1;
    prev = ramp_l; prev_dir = left_dir; flips = 0;
    for (int t = 0; t < 70; t++) begin
      step();
      checks++;
      if (right_pwm !== 1'b1) begin errors++; $display("FAIL fl_right_pwm: got %b expected 1", right_pwm); end
      if (ramp_l !== prev) begin
        checks++;
        if (int'(ramp_l) - int'(prev) != -2) begin
          errors++; $display("FAIL fl_step: delta=%0d expected -2", int'(ramp_l) - int'(prev));
        end
        prev = ramp_l;
      end
      if (left_dir !== prev_dir) begin
        flips++;
        checks++;
        if (left_dir !== 1'b0 || dut.pwm_cnt_reg !== 4'd0 || ramp_l >= 0) begin
          errors++;
          $display("FAIL fl_dir_flip: dir=%b cnt=%0d ramp=%0d expected 0/0/<0", left_dir, dut.pwm_cnt_reg, ramp_l);
        end
        prev_dir = left_dir;
      end
    end
    checks++;
    if (flips != 1 || left_dir !== 1'b0 || ramp_l !== -6'sd10) begin
      errors++; $display("FAIL fl_final: flips=%0d dir=%b ramp=%0d expected 1/0/-10", flips, left_dir, ramp_l);
    end
    count_high(10, lc, rc);
    checks++;
    if (lc != 10 || rc != 10) begin errors++; $display("FAIL fl_pwm: got %0d/%0d expected 10/10", lc, rc); end
    $display("test_fast_left done");
  endtask

  task automatic test_turns();
    logic signed [5:0] pl, pr;
    int nchg, lc, rc;
    valid = 1'b1; drive_command = 3'd3;
    repeat (60) step();
    checks++;
    if (ramp_l !== 6'sd10) begin errors++; $display("FAIL turn_pre: ramp_l=%0d expected 10", ramp_l); end
    drive_command = 3'd2;
    pl = ramp_l; pr = ramp_r; nchg = 0;
    for (int t = 0; t < 20 && nchg < 2; t++) begin
      step();
      if (ramp_l !== pl) begin
        nchg++;
        checks++;
        if (int'(ramp_l) - int'(pl) != -2) begin
          errors++; $display("FAIL turn_left_step: delta=%0d expected -2", int'(ramp_l) - int'(pl));
        end
        pl = ramp_l;
      end
    end
    checks++;
    if (nchg != 2 || ramp_l !== 6'sd6 || ramp_r !== 6'sd10) begin
      errors++; $display("FAIL turn_mid: steps=%0d L=%0d R=%0d expected 2/6/10", nchg, ramp_l, ramp_r);
    end
    drive_command = 3'd4;
    pl = ramp_l; pr = ramp_r;
    for (int t = 0; t < 40; t++) begin
      step();
      checks++;
      if (int'(ramp_l) - int'(pl) > 2 || int'(ramp_l) - int'(pl) < -2 ||
          int'(ramp_r) - int'(pr) > 2 || int'(ramp_r) - int'(pr) < -2 || ramp_l < 6) begin
        errors++;
        $display("FAIL turn_slew: L %0d->%0d R %0d->%0d expected steps<=2, L>=6", pl, ramp_l, pr, ramp_r);
      end
      pl = ramp_l; pr = ramp_r;
    end
    checks++;
    if (ramp_l !== 6'sd10 || ramp_r !== 6'sd4) begin
      errors++; $display("FAIL turn_final: L=%0d R=%0d expected 10/4", ramp_l, ramp_r);
    end
    count_high(10, lc, rc);
    checks++;
    if (lc != 10 || rc != 4) begin errors++; $display("FAIL turn_pwm: got %0d/%0d expected 10/4", lc, rc); end
    $display("test_turns done");
  endtask

  task automatic test_watchdog();
    int lc, rc;
    bit seen;
    valid = 1'b1; drive_command = 3'd3;
    repeat (60) step();
    valid = 1'b0;
    repeat (99) step();
    checks++;
    if (watchdog_fault !== 1'b0) begin errors++; $display("FAIL wd_early: got %b expected 0", watchdog_fault); end
    valid = 1'b1;
    step();
    checks++;
    if (watchdog_fault !== 1'b0) begin errors++; $display("FAIL wd_valid_wins: got %b expected 0", watchdog_fault); end
    valid = 1'b0;
    repeat (99) step();
    checks++;
    if (watchdog_fault !== 1'b0) begin errors++; $display("FAIL wd_before_expiry: got %b expected 0", watchdog_fault); end
    step();
    checks++;
    if (watchdog_fault !== 1'b1) begin errors++; $display("FAIL wd_expiry: got %b expected 1", watchdog_fault); end
    repeat (35) step();
    checks++;
    if (moving !== 1'b0 || watchdog_fault !== 1'b1 || ramp_l !== 6'sd0) begin
      errors++; $display("FAIL wd_stopped: moving=%b fault=%b L=%0d expected 0/1/0", moving, watchdog_fault, ramp_l);
    end
    count_high(10, lc, rc);
    checks++;
    if (lc + rc != 0 || {left_dir, right_dir} !== 2'b11) begin
      errors++; $display("FAIL wd_pwm: high=%0d dirs=%b expected 0/11", lc + rc, {left_dir, right_dir});
    end
    valid = 1'b1; drive_command = 3'd3;
    step();
    checks++;
    if (watchdog_fault !== 1'b0) begin errors++; $display("FAIL wd_clear: got %b expected 0", watchdog_fault); end
    seen = 1'b0;
    for (int t = 0; t < 6 && !seen; t++) begin
      step();
      if (ramp_l == 6'sd2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL wd_restart: ramp_l=%0d expected 2 within 6 cycles", ramp_l); end
    $display("test_watchdog done");
  endtask

  task automatic test_stop_reset();
    bit seen;
    valid = 1'b1; drive_command = 3'd3;
    repeat (30) step();
    drive_command = 3'd7;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      step();
      if (ramp_l == 6'sd6) seen = 1'b1;
    end
    checks++;
    if (!seen || ramp_r !== 6'sd6) begin
      errors++; $display("FAIL code7_ramp: L=%0d R=%0d expected 6/6", ramp_l, ramp_r);
    end
    reset = 1'b1;
    step();
    checks++;
    if (ramp_l !== 6'sd0 || ramp_r !== 6'sd0 || {left_pwm, right_pwm, moving} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_ramp: L=%0d R=%0d pwm/mov=%b expected 0/0/000", ramp_l, ramp_r, {left_pwm, right_pwm, moving});
    end
    checks++;
    if ({left_dir, right_dir} !== 2'b11) begin
      errors++; $display("FAIL reset_mid_dirs: got %b expected 11", {left_dir, right_dir});
    end
    reset = 1'b0; valid = 1'b0;
    step();
    $display("test_stop_reset done");
  endtask

  initial begin
    test_reset();
    test_straight();
    test_fast_left();
    test_turns();
    test_watchdog();
    test_stop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
